// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_resp_pkg
// Description : Shared types and constants for the CPU memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_resp_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    // Byte address = word index << BYTE_OFS_W
    localparam int BYTE_OFS_W = 2;
    localparam int WORD_BYTES = 1 << BYTE_OFS_W;

endpackage
`default_nettype wire

// File: rtl/cpu_mem_responder_word_ram.sv
`default_nettype none
// ============================================================================
// Module      : word_ram
// Description : 32-bit word array, one synchronous write port, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module word_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_responder
// Description : IMEM/DMEM responder for the pipelined CPU with a streaming
//               instruction loader that holds the core while it fills IMEM.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int IMEM_AW   = 10,
    parameter int DMEM_AW   = 10,
    parameter int BOOT_LOAD = 1,
    parameter int FLUSH_CYC = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        imem_addr,
    output logic [31:0]        imem_data,
    input  logic [31:0]        dmem_addr,
    input  logic [31:0]        dmem_wdata,
    input  logic               dmem_we,
    output logic [31:0]        dmem_rdata,
    input  logic               ld_start,
    input  logic               ld_valid,
    input  logic [31:0]        ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               cpu_hold,
    output logic [IMEM_AW:0]   load_count,
    output logic               addr_err
);

    localparam int                  C_FLUSH_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [C_FLUSH_W-1:0] C_FLUSH_LAST = C_FLUSH_W'(FLUSH_CYC - 1);
    localparam logic [IMEM_AW:0]    C_DEPTH      = {1'b1, {IMEM_AW{1'b0}}};
    localparam state_t              C_RST_STATE  = (BOOT_LOAD != 0) ? LOAD : RUN;

    state_t                 r_state, w_state_nxt;
    logic [IMEM_AW:0]       r_load_count, w_load_count_nxt;
    logic [C_FLUSH_W-1:0]   r_flush_cnt, w_flush_cnt_nxt;
    logic                   r_addr_err, w_addr_err_nxt;
    logic                   r_cpu_hold;
    logic                   r_ld_ready;

    logic                   w_imem_ok;
    logic                   w_dmem_ok;
    logic                   w_ld_accept;
    logic                   w_dmem_we;
    logic [31:0]            w_imem_rd;
    logic [31:0]            w_dmem_rd;
    logic                   w_unused;

    assign w_imem_ok   = (imem_addr >> (IMEM_AW + BYTE_OFS_W)) == 32'd0;
    assign w_dmem_ok   = (dmem_addr >> (DMEM_AW + BYTE_OFS_W)) == 32'd0;
    assign w_ld_accept = ld_valid && r_ld_ready;
    assign w_dmem_we   = (r_state == RUN) && dmem_we && w_dmem_ok;
    // Sub-word byte offsets are deliberately ignored; no misalignment trap.
    assign w_unused    = ^{imem_addr[BYTE_OFS_W-1:0], dmem_addr[BYTE_OFS_W-1:0]};

    always_comb begin
        w_state_nxt      = r_state;
        w_load_count_nxt = r_load_count;
        w_flush_cnt_nxt  = r_flush_cnt;
        w_addr_err_nxt   = r_addr_err;
        unique case (r_state)
            RUN: begin
                if (!w_imem_ok || !w_dmem_ok) begin
                    w_addr_err_nxt = 1'b1;
                end
                if (ld_start) begin
                    w_state_nxt      = LOAD;
                    w_load_count_nxt = '0;
                    w_addr_err_nxt   = 1'b0;
                end
            end
            LOAD: begin
                if (w_ld_accept) begin
                    w_load_count_nxt = r_load_count + 1'b1;
                    // Full depth and ld_last together still yield one transition
                    if (ld_last || (w_load_count_nxt == C_DEPTH)) begin
                        w_state_nxt     = FLUSH;
                        w_flush_cnt_nxt = '0;
                    end
                end
            end
            FLUSH: begin
                if (r_flush_cnt == C_FLUSH_LAST) begin
                    w_state_nxt = RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = C_RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= C_RST_STATE;
            r_load_count <= '0;
            r_flush_cnt  <= '0;
            r_addr_err   <= 1'b0;
            r_cpu_hold   <= (BOOT_LOAD != 0);
            r_ld_ready   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_load_count <= w_load_count_nxt;
            r_flush_cnt  <= w_flush_cnt_nxt;
            r_addr_err   <= w_addr_err_nxt;
            // Handshake outputs are registered so they only move on edges
            r_cpu_hold   <= (w_state_nxt != RUN);
            r_ld_ready   <= (w_state_nxt == LOAD) && (w_load_count_nxt < C_DEPTH);
        end
    end

    word_ram #(.AW(IMEM_AW)) u_imem (
        .clk   (clk),
        .we    (w_ld_accept),
        .waddr (r_load_count[IMEM_AW-1:0]),
        .wdata (ld_data),
        .raddr (imem_addr[IMEM_AW+BYTE_OFS_W-1:BYTE_OFS_W]),
        .rdata (w_imem_rd)
    );

    word_ram #(.AW(DMEM_AW)) u_dmem (
        .clk   (clk),
        .we    (w_dmem_we),
        .waddr (dmem_addr[DMEM_AW+BYTE_OFS_W-1:BYTE_OFS_W]),
        .wdata (dmem_wdata),
        .raddr (dmem_addr[DMEM_AW+BYTE_OFS_W-1:BYTE_OFS_W]),
        .rdata (w_dmem_rd)
    );

    assign imem_data  = (r_cpu_hold || !w_imem_ok) ? NOP_INST : w_imem_rd;
    assign dmem_rdata = w_dmem_ok ? w_dmem_rd : 32'd0;
    assign cpu_hold   = r_cpu_hold;
    assign ld_ready   = r_ld_ready;
    assign load_count = r_load_count;
    assign addr_err   = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem_responder
// Description : Scoreboard bench for cpu_mem_responder (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_responder;

    localparam int IMEM_AW = 10;
    localparam int DMEM_AW = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [31:0]        imem_addr = '0;
    logic [31:0]        imem_data;
    logic [31:0]        dmem_addr = '0;
    logic [31:0]        dmem_wdata = '0;
    logic               dmem_we = 1'b0;
    logic [31:0]        dmem_rdata;
    logic               ld_start = 1'b0;
    logic               ld_valid = 1'b0;
    logic [31:0]        ld_data = '0;
    logic               ld_last = 1'b0;
    logic               ld_ready;
    logic               cpu_hold;
    logic [IMEM_AW:0]   load_count;
    logic               addr_err;

    always #5 clk = ~clk;

    cpu_mem_responder #(
        .IMEM_AW   (IMEM_AW),
        .DMEM_AW   (DMEM_AW),
        .BOOT_LOAD (1),
        .FLUSH_CYC (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .cpu_hold   (cpu_hold),
        .load_count (load_count),
        .addr_err   (addr_err)
    );

    typedef enum int {K_IMEM, K_DMEM, K_HOLD, K_READY, K_CNT, K_ERR} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void push(input kind_t k, input logic [31:0] v, input string n);
        exp_t e;
        e.kind = k;
        e.exp  = v;
        e.name = n;
        sb.push_back(e);
    endfunction

    // Expectations queued during a cycle are compared at that cycle's falling edge
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_IMEM:  act = imem_data;
                K_DMEM:  act = dmem_rdata;
                K_HOLD:  act = {31'd0, cpu_hold};
                K_READY: act = {31'd0, ld_ready};
                K_CNT:   act = 32'(load_count);
                default: act = {31'd0, addr_err};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: actual 0x%08h required 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int n;
        n        = 0;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        while (!ld_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (!ld_ready) begin
            errors++;
            $display("FAIL ld_ready_timeout: actual 0 required 1 for word 0x%08h", d);
        end
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (cpu_hold && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (cpu_hold) begin
            errors++;
            $display("FAIL hold_release_timeout: actual cpu_hold 1 required 0");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog1 [4];
        logic [31:0] prog2 [3];
        prog1 = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h00000013};
        prog2 = '{32'h00A00093, 32'h00B00113, 32'h00C00193};

        // Reset values with BOOT_LOAD=1
        step();
        push(K_HOLD, 1, "rst_hold");
        push(K_READY, 0, "rst_ready");
        push(K_CNT, 0, "rst_count");
        push(K_ERR, 0, "rst_err");
        push(K_IMEM, 32'h13, "rst_imem_nop");
        step();
        rst = 1'b1;
        step();
        push(K_READY, 1, "boot_ready");
        push(K_HOLD, 1, "boot_hold");

        // Boot load of four words, then exact five-cycle flush
        imem_addr = 32'h8;
        for (int i = 0; i < 4; i++) begin
            send_word(prog1[i], i == 3);
            push(K_CNT, 32'(i + 1), "boot_count");
            push(K_HOLD, 1, "boot_hold_load");
            push(K_IMEM, 32'h13, "boot_imem_nop");
        end
        push(K_READY, 0, "flush_ready");
        for (int i = 0; i < 4; i++) begin
            step();
            push(K_HOLD, 1, "flush_hold");
        end
        step();
        push(K_HOLD, 0, "run_hold");
        push(K_IMEM, 32'h002081B3, "run_imem_8");
        push(K_ERR, 0, "run_err");
        step();
        imem_addr = 32'h0;
        push(K_IMEM, 32'h00500093, "run_imem_0");
        step();

        // Data writes: old value same cycle, new value next cycle
        dmem_we = 1'b1;
        dmem_addr = 32'h0;  dmem_wdata = 32'hCAFEF00D; step();
        dmem_addr = 32'h20; dmem_wdata = 32'h55AA55AA; step();
        dmem_addr = 32'h10; dmem_wdata = 32'h11111111; step();
        dmem_wdata = 32'hDEADBEEF;
        push(K_DMEM, 32'h11111111, "wr_same_cycle_old");
        step();
        dmem_we = 1'b0;
        push(K_DMEM, 32'hDEADBEEF, "wr_next_cycle");
        step();
        dmem_addr = 32'h13;
        push(K_DMEM, 32'hDEADBEEF, "wr_byte_offset");
        push(K_ERR, 0, "wr_no_err");
        step();

        // Out-of-range data access
        dmem_addr = 32'h1000;
        push(K_DMEM, 0, "oor_rdata");
        step();
        push(K_ERR, 1, "oor_err_set");
        dmem_we = 1'b1; dmem_wdata = 32'h12345678;
        step();
        dmem_we = 1'b0; dmem_addr = 32'h0;
        push(K_DMEM, 32'hCAFEF00D, "oor_write_dropped");
        push(K_ERR, 1, "oor_err_sticky");
        step();
        ld_start = 1'b1;
        step();
        push(K_ERR, 0, "ld_start_clears_err");
        push(K_HOLD, 1, "reload_hold");
        push(K_READY, 1, "reload_ready");
        push(K_CNT, 0, "reload_count");

        // Reload with toggling valid; DMEM writes and ld_start must be ignored
        dmem_addr = 32'h20; dmem_wdata = 32'hBADBAD00; dmem_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_word(prog2[i], i == 2);
            push(K_CNT, 32'(i + 1), "toggle_count_acc");
            if (i < 2) begin
                ld_data = 32'hFFFFFFFF;
                step();
                push(K_CNT, 32'(i + 1), "toggle_count_idle");
            end
        end
        push(K_HOLD, 1, "reload_flush_hold");
        push(K_READY, 0, "reload_flush_ready");
        for (int i = 0; i < 4; i++) begin
            step();
            push(K_HOLD, 1, "reload_flush_start_ignored");
        end
        ld_start = 1'b0;
        dmem_we  = 1'b0;
        step();
        push(K_HOLD, 0, "reload_run");
        push(K_DMEM, 32'h55AA55AA, "load_dmem_unchanged");
        imem_addr = 32'h8;
        push(K_IMEM, 32'h00C00193, "reload_imem_8");
        step();
        imem_addr = 32'h4;
        push(K_IMEM, 32'h00B00113, "reload_imem_4");
        step();

        // Reset mid-load aborts; already-written words remain
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        send_word(32'hAAAA0001, 1'b0);
        send_word(32'hAAAA0002, 1'b0);
        push(K_CNT, 2, "abort_count_before");
        step();
        rst = 1'b0;
        #1;
        push(K_HOLD, 1, "abort_hold");
        push(K_READY, 0, "abort_ready");
        push(K_CNT, 0, "abort_count");
        push(K_ERR, 0, "abort_err");
        step();
        rst = 1'b1;
        step();
        push(K_READY, 1, "restart_ready");
        push(K_CNT, 0, "restart_count");
        send_word(32'hBBBB0000, 1'b1);
        push(K_CNT, 1, "restart_count_1");
        wait_run();
        imem_addr = 32'h0;
        push(K_IMEM, 32'hBBBB0000, "restart_word0");
        step();
        imem_addr = 32'h4;
        push(K_IMEM, 32'hAAAA0002, "abort_word1_kept");
        step();
        imem_addr = 32'h8;
        push(K_IMEM, 32'h00C00193, "abort_word2_kept");
        step();

        // Out-of-range fetch returns NOP and sets addr_err
        imem_addr = 32'h4000;
        push(K_IMEM, 32'h13, "oor_fetch_nop");
        push(K_ERR, 0, "oor_fetch_err_before");
        step();
        push(K_ERR, 1, "oor_fetch_err_set");
        imem_addr = 32'h0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the five-stage pipelined CPU.
- Serves the IF-stage instruction fetch (PC in, instruction out) and the Mem-stage data access (address, write data and MemRW in; read data out).
- Owns an instruction loader: a valid/ready word stream that fills instruction memory while the CPU is held.
- Sits at top level between the CPU core and the board I/O / loader source.

Parameters:
- IMEM_AW, 10, word-address width of instruction memory (depth 2^IMEM_AW words).
- DMEM_AW, 10, word-address width of data memory (depth 2^DMEM_AW words).
- BOOT_LOAD, 1, 1 = leave reset in LOAD state; 0 = leave reset in RUN.
- FLUSH_CYC, 5, cycles cpu_hold stays high after a load completes (pipeline drain).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_addr  in  32  byte address from the IF-stage PC.
- imem_data  out  32  instruction word to the IF stage.
- dmem_addr  in  32  byte address from the Mem-stage ALU result.
- dmem_wdata  in  32  store data from Mem-stage rs2.
- dmem_we  in  1  Mem-stage MemRW; 1 = write.
- dmem_rdata  out  32  load data to the Mem/WB register.
- ld_start  in  1  pulse; requests a reload (honoured only in RUN).
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader instruction word.
- ld_last  in  1  marks the final loader word.
- ld_ready  out  1  responder accepts a loader word this cycle.
- cpu_hold  out  1  1 = CPU must be held in reset/stall.
- load_count  out  IMEM_AW+1  number of words written by the current/last load.
- addr_err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset (rst=0, async):
  - state = LOAD if BOOT_LOAD, else RUN.
  - cpu_hold = BOOT_LOAD; ld_ready = 0; load_count = 0; addr_err = 0; flush counter = 0.
  - Memory contents are not reset.
- Addressing:
  - Word index = addr[AW+1:2]; addr[1:0] ignored (no misalignment trap).
  - An address is in range iff addr[31:AW+2] == 0.
- Reads:
  - Combinational from the array, zero latency. This matches the CPU, which captures data at the Mem/WB edge.
  - imem_data = 0x00000013 (NOP) when cpu_hold=1 or imem_addr is out of range.
  - dmem_rdata = 0 when dmem_addr is out of range.
- Data writes:
  - Occur on the rising edge when state=RUN, dmem_we=1 and the address is in range.
  - Writes in LOAD/FLUSH are dropped.
  - Same-cycle read of the written word returns the old value; the new value is visible the next cycle.
- addr_err:
  - Set on the edge where state=RUN and an out-of-range dmem access occurs (read or write), or an out-of-range imem fetch occurs.
  - Cleared only by reset or by an accepted ld_start.
- FSM:
  - RUN:
    - cpu_hold=0, ld_ready=0.
    - ld_start=1 -> LOAD; load_count<=0; addr_err<=0.
  - LOAD:
    - cpu_hold=1; ld_ready = (load_count < 2^IMEM_AW).
    - On ld_valid&&ld_ready: imem[load_count] <= ld_data; load_count++.
    - If that accepted word has ld_last=1, or load_count reaches 2^IMEM_AW -> FLUSH, flush counter <= 0.
    - ld_valid without ready: no write; the word must be held by the source.
    - ld_start is ignored in this state.
  - FLUSH:
    - cpu_hold=1, ld_ready=0.
    - Counter increments each cycle; when it reaches FLUSH_CYC-1 -> RUN.
    - ld_start is ignored in this state.
- Boundary cases:
  - The last word at full depth and ld_last in the same cycle give a single transition to FLUSH.
  - A load of 0 words is impossible; a word must carry ld_last.
  - Reset asserted mid-load aborts the load. Words already written remain; load_count is cleared.
- cpu_hold and ld_ready are registered-state decodes: glitch-free, and they change only on clock edges or reset.

Decomposition:
- Package mem_resp_pkg holds:
  - state enum {RUN, LOAD, FLUSH};
  - NOP_INST = 32'h00000013;
  - word/byte address helper constants.
- Sub-module word_ram (parameter AW): sync write, async read, one write port.
  - Instantiated twice.
  - IMEM instance: loader drives its write port.
  - DMEM instance: CPU drives its write port.

Test Plan:
- BOOT_LOAD=1 reset release, stream 4 words 0x00500093,0x00100113,0x002081B3,0x00000013 with ld_last on the 4th:
  - cpu_hold=1 throughout; imem_data=0x13 during hold;
  - load_count=4; FLUSH lasts 5 cycles; then cpu_hold=0;
  - imem_addr=0x8 then returns 0x002081B3.
- RUN, dmem_we=1, addr 0x10, data 0xDEADBEEF:
  - same-cycle dmem_rdata shows the old value;
  - next cycle reading 0x10 and 0x13 both return 0xDEADBEEF.
- RUN, dmem read at 0x0000_1000 with DMEM_AW=10:
  - dmem_rdata=0 and addr_err=1 after the edge.
  - A write to 0x1000 leaves word 0 unchanged.
  - ld_start clears addr_err.
- LOAD with ld_valid toggling every other cycle: only cycles with valid&&ready write, and load_count tracks exactly.
- In LOAD, dmem_we=1 at 0x20: memory is unchanged; ld_start pulses in LOAD/FLUSH are ignored.
- rst pulled low after 2 of 4 loader words:
  - outputs return to reset values (load_count=0);
  - a fresh load restarts writing at word 0.
